// File: rtl/verificador_salidas_checker_if.sv
// Expected/actual word streams feeding the response checker.
// The tester side drives both streams; the checker only observes them.
interface verificador_salidas_checker_if #(
  parameter int WIDTH = 2
);
  logic             expected_valid;
  logic [WIDTH-1:0] expected_data;
  logic             actual_valid;
  logic [WIDTH-1:0] actual_data;

  modport master (
    output expected_valid, expected_data, actual_valid, actual_data
  );

  modport slave (
    input  expected_valid, expected_data, actual_valid, actual_data
  );
endinterface

// File: rtl/verificador_salidas_checker.sv
// Response checker: aligns golden and DUT streams in two FIFOs, compares heads pairwise,
// and keeps saturating match/error counts plus a snapshot of the first mismatch.
module verificador_salidas_checker #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 start,
  input  logic                 end_test,
  verificador_salidas_checker_if.slave stream,
  output logic [CNT_W-1:0]     match_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [CNT_W-1:0]     first_err_index,
  output logic [WIDTH-1:0]     first_err_expected,
  output logic [WIDTH-1:0]     first_err_actual,
  output logic                 error_flag,
  output logic                 overflow,
  output logic                 done,
  output logic                 pass
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] MAXV = (32'd1 << CNT_W) - 32'd1;

  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     exp_mem_q [DEPTH];
  logic [WIDTH-1:0]     act_mem_q [DEPTH];
  logic [PW-1:0]        exp_wr_q, exp_wr_d, exp_rd_q, exp_rd_d;
  logic [PW-1:0]        act_wr_q, act_wr_d, act_rd_q, act_rd_d;
  logic [CW-1:0]        exp_cnt_q, exp_cnt_d, act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0]     match_q, match_d, err_q, err_d, idx_q, idx_d, fe_idx_q, fe_idx_d;
  logic [WIDTH-1:0]     fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;
  logic                 eflag_q, eflag_d, ovf_q, ovf_d;
  logic                 exp_push, act_push, pop, clr, drain_end;
  logic [WIDTH-1:0]     exp_head, act_head;
  logic                 both_ne;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CW-1:0]    b);
    logic [31:0] s;
    s = 32'(a) + 32'(b);
    if (s > MAXV) return MAXV[CNT_W-1:0];
    return s[CNT_W-1:0];
  endfunction

  assign exp_head = exp_mem_q[exp_rd_q];
  assign act_head = act_mem_q[act_rd_q];
  assign both_ne  = (exp_cnt_q != '0) && (act_cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    exp_push  = 1'b0;
    act_push  = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    drain_end = 1'b0;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (start) begin
          clr = 1'b1;
        end else begin
          pop = both_ne;
          // A full FIFO still accepts a word when its head leaves on the same edge.
          exp_push = stream.expected_valid && ((exp_cnt_q != CW'(DEPTH)) || pop);
          act_push = stream.actual_valid   && ((act_cnt_q != CW'(DEPTH)) || pop);
          if ((stream.expected_valid && !exp_push) || (stream.actual_valid && !act_push))
            ovf_d = 1'b1;
          if (end_test) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (start) begin
          clr     = 1'b1;
          state_d = CHECK;
        end else if (both_ne) begin
          pop = 1'b1;
        end else begin
          drain_end = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    exp_wr_d  = exp_wr_q + PW'(exp_push);
    act_wr_d  = act_wr_q + PW'(act_push);
    exp_rd_d  = exp_rd_q + PW'(pop);
    act_rd_d  = act_rd_q + PW'(pop);
    exp_cnt_d = exp_cnt_q + CW'(exp_push) - CW'(pop);
    act_cnt_d = act_cnt_q + CW'(act_push) - CW'(pop);
    match_d   = match_q;
    err_d     = err_q;
    idx_d     = idx_q;
    fe_idx_d  = fe_idx_q;
    fe_exp_d  = fe_exp_q;
    fe_act_d  = fe_act_q;
    eflag_d   = eflag_q;

    if (pop) begin
      idx_d = idx_q + CNT_W'(1);
      if (exp_head == act_head) begin
        match_d = sat_add(match_q, CW'(1));
      end else begin
        err_d = sat_add(err_q, CW'(1));
        if (!eflag_q) begin
          eflag_d  = 1'b1;
          fe_idx_d = idx_q;
          fe_exp_d = exp_head;
          fe_act_d = act_head;
        end
      end
    end

    // At least one FIFO is empty here, so the sum is the leftover occupancy.
    if (drain_end) begin
      err_d = sat_add(err_q, exp_cnt_q + act_cnt_q);
      if ((exp_cnt_q + act_cnt_q) != '0) eflag_d = 1'b1;
    end

    if (drain_end || clr) begin
      exp_wr_d  = '0;
      act_wr_d  = '0;
      exp_rd_d  = '0;
      act_rd_d  = '0;
      exp_cnt_d = '0;
      act_cnt_d = '0;
    end

    if (clr) begin
      match_d  = '0;
      err_d    = '0;
      idx_d    = '0;
      fe_idx_d = '0;
      fe_exp_d = '0;
      fe_act_d = '0;
      eflag_d  = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      exp_wr_q  <= '0;
      exp_rd_q  <= '0;
      act_wr_q  <= '0;
      act_rd_q  <= '0;
      exp_cnt_q <= '0;
      act_cnt_q <= '0;
      match_q   <= '0;
      err_q     <= '0;
      idx_q     <= '0;
      fe_idx_q  <= '0;
      fe_exp_q  <= '0;
      fe_act_q  <= '0;
      eflag_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_wr_q  <= exp_wr_d;
      exp_rd_q  <= exp_rd_d;
      act_wr_q  <= act_wr_d;
      act_rd_q  <= act_rd_d;
      exp_cnt_q <= exp_cnt_d;
      act_cnt_q <= act_cnt_d;
      match_q   <= match_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      fe_idx_q  <= fe_idx_d;
      fe_exp_q  <= fe_exp_d;
      fe_act_q  <= fe_act_d;
      eflag_q   <= eflag_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage holds only data; occupancy lives in the counters above.
  always_ff @(posedge clk) begin
    if (exp_push) exp_mem_q[exp_wr_q] <= stream.expected_data;
    if (act_push) act_mem_q[act_wr_q] <= stream.actual_data;
  end

  assign match_count        = match_q;
  assign error_count        = err_q;
  assign first_err_index    = fe_idx_q;
  assign first_err_expected = fe_exp_q;
  assign first_err_actual   = fe_act_q;
  assign error_flag         = eflag_q;
  assign overflow           = ovf_q;
  assign done               = (state_q == DONE);
  assign pass               = done && (err_q == '0) && !ovf_q;

endmodule
